// File: rtl/imem_loader.sv
// imem_loader: byte-stream writer for the core's 64-word instruction RAM.
// Packs bytes little-endian into 32-bit words, clears the RAM before every
// load, and holds the core off until a clean program is resident.
module imem_loader #(
   parameter int unsigned N     = 32,
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    in_byte,
   input  logic          in_last,
   input  logic [AW-1:0] addr,
   output logic [N-1:0]  q,
   output logic          cpu_hold,
   output logic          done,
   output logic          err,
   output logic [AW:0]   words_loaded
);

   localparam int unsigned WLW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_LOAD  = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_e;

   state_e         state_q, state_d;
   logic [AW-1:0]  clr_idx_q, clr_idx_d;
   logic [1:0]     lane_q, lane_d;
   logic [N-1:0]   word_q, word_d;
   logic [WLW-1:0] wl_q, wl_d;
   logic           in_ready_q, cpu_hold_q, done_q, err_q;

   logic           accept_c;
   logic [N-1:0]   asm_c;
   logic           we_c;
   logic [AW-1:0]  waddr_c;
   logic [N-1:0]   wdata_c;

   logic [N-1:0]   mem [DEPTH];

   // Next-state, lane assembly and RAM write-port control.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      lane_d    = lane_q;
      word_d    = word_q;
      wl_d      = wl_q;
      we_c      = 1'b0;
      waddr_c   = '0;
      wdata_c   = '0;
      accept_c  = in_valid & in_ready_q;
      asm_c     = word_q | (N'(in_byte) << {lane_q, 3'b000});

      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d   = S_CLEAR;
               clr_idx_d = '0;
               lane_d    = '0;
               word_d    = '0;
               wl_d      = '0;
            end
         end
         S_CLEAR: begin
            we_c      = 1'b1;
            waddr_c   = clr_idx_q;
            clr_idx_d = clr_idx_q + AW'(1);
            if (clr_idx_q == AW'(DEPTH - 1)) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (accept_c) begin
               if (wl_q == WLW'(DEPTH)) begin
                  // RAM full: discard the byte rather than wrap to entry 0
                  state_d = S_ERR;
               end else if ((lane_q == 2'd3) || in_last) begin
                  we_c    = 1'b1;
                  waddr_c = wl_q[AW-1:0];
                  wdata_c = asm_c;
                  wl_d    = wl_q + WLW'(1);
                  lane_d  = '0;
                  word_d  = '0;
                  if (in_last) begin
                     state_d = (lane_q == 2'd3) ? S_DONE : S_ERR;
                  end
               end else begin
                  lane_d = lane_q + 2'd1;
                  word_d = asm_c;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs; outputs are decoded from the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         clr_idx_q  <= '0;
         lane_q     <= '0;
         word_q     <= '0;
         wl_q       <= '0;
         in_ready_q <= 1'b0;
         cpu_hold_q <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_idx_q  <= clr_idx_d;
         lane_q     <= lane_d;
         word_q     <= word_d;
         wl_q       <= wl_d;
         in_ready_q <= (state_d == S_LOAD);
         cpu_hold_q <= (state_d != S_DONE);
         done_q     <= (state_d == S_DONE);
         err_q      <= (state_d == S_ERR);
      end
   end

   // Instruction RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (we_c) begin
         mem[waddr_c] <= wdata_c;
      end
   end

   assign q            = mem[addr];
   assign in_ready     = in_ready_q;
   assign cpu_hold     = cpu_hold_q;
   assign done         = done_q;
   assign err          = err_q;
   assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table of load scenarios with random bytes,
// checked against a byte-packing reference model, plus hand-written corners.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_byte;
   logic        in_last;
   logic [5:0]  addr;
   logic [31:0] q;
   logic        cpu_hold;
   logic        done;
   logic        err;
   logic [6:0]  words_loaded;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] bq[$];

   typedef struct {
      int nbytes;
      bit last;
      bit bubbles;
      int exp_words;
      bit exp_done;
      bit exp_err;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   imem_loader dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_byte      (in_byte),
      .in_last      (in_last),
      .addr         (addr),
      .q            (q),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: word w holds bytes 4w..4w+3 of the accepted stream, missing bytes zero.
   task automatic check_mem(input int lim);
      logic [31:0] e;
      for (int w = 0; w < 64; w++) begin
         e = '0;
         for (int b = 0; b < 4; b++) begin
            if (4 * w + b < lim) e[8*b +: 8] = bq[4*w+b];
         end
         addr = 6'(w);
         #1;
         chk($sformatf("mem[%0d]", w), q, e);
      end
   endtask

   task automatic start_and_clear();
      int cnt;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt = 0;
      while (!in_ready && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
      chk("clear_cycles", 32'(cnt), 32'd64);
      chk("hold_in_load", 32'(cpu_hold), 32'd1);
      addr = 6'd63;
      #1;
      chk("q63_cleared", q, 32'h0);
      addr = 6'd0;
      #1;
      chk("q0_cleared", q, 32'h0);
   endtask

   task automatic send(input bit with_last, input bit bubbles);
      int guard;
      bit sent;
      for (int i = 0; i < bq.size(); i++) begin
         guard = 0;
         sent  = 1'b0;
         while (!sent) begin
            @(negedge clk);
            if (bubbles && $urandom_range(0, 2) == 0) begin
               in_valid = 1'b0;
               in_byte  = 8'($urandom);
               in_last  = 1'($urandom);
            end else begin
               in_valid = 1'b1;
               in_byte  = bq[i];
               in_last  = with_last && (i == bq.size() - 1);
               if (in_ready) sent = 1'b1;
            end
            guard++;
            if (guard > 50 && !sent) begin
               n_tests++;
               n_fail++;
               $display("FAIL send_timeout: byte %0d never accepted", i);
               in_valid = 1'b0;
               in_last  = 1'b0;
               return;
            end
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_status(input string tag, input int words, input bit d, input bit e);
      chk({tag, "_done"}, 32'(done), 32'(d));
      chk({tag, "_err"}, 32'(err), 32'(e));
      chk({tag, "_words"}, 32'(words_loaded), 32'(words));
      chk({tag, "_hold"}, 32'(cpu_hold), 32'(!d));
      chk({tag, "_ready"}, 32'(in_ready), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_words"}, 32'(words_loaded), 32'd0);
   endtask

   initial begin
      vecs[0] = '{nbytes: 8,   last: 1'b1, bubbles: 1'b1, exp_words: 2,  exp_done: 1'b1, exp_err: 1'b0};
      vecs[1] = '{nbytes: 6,   last: 1'b1, bubbles: 1'b0, exp_words: 2,  exp_done: 1'b0, exp_err: 1'b1};
      vecs[2] = '{nbytes: 1,   last: 1'b1, bubbles: 1'b1, exp_words: 1,  exp_done: 1'b0, exp_err: 1'b1};
      vecs[3] = '{nbytes: 4,   last: 1'b1, bubbles: 1'b0, exp_words: 1,  exp_done: 1'b1, exp_err: 1'b0};
      vecs[4] = '{nbytes: 257, last: 1'b0, bubbles: 1'b1, exp_words: 64, exp_done: 1'b0, exp_err: 1'b1};
      vecs[5] = '{nbytes: 256, last: 1'b1, bubbles: 1'b0, exp_words: 64, exp_done: 1'b1, exp_err: 1'b0};
      vecs[6] = '{nbytes: 255, last: 1'b1, bubbles: 1'b1, exp_words: 64, exp_done: 1'b0, exp_err: 1'b1};
      vecs[7] = '{nbytes: 11,  last: 1'b1, bubbles: 1'b1, exp_words: 3,  exp_done: 1'b0, exp_err: 1'b1};

      reset_n  = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_byte  = 8'h00;
      in_last  = 1'b0;
      addr     = 6'd0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      reset_n = 1'b1;

      // Nine-word program with a known first word
      bq.delete();
      bq.push_back(8'hc9); bq.push_back(8'h03); bq.push_back(8'h1f); bq.push_back(8'h8b);
      for (int i = 4; i < 36; i++) bq.push_back(8'($urandom));
      start_and_clear();
      send(1'b1, 1'b0);
      check_status("prog9", 9, 1'b1, 1'b0);
      addr = 6'd0;
      #1;
      chk("prog9_q0", q, 32'h8b1f03c9);
      check_mem(36);

      // Partial final word is padded, written, and flagged
      bq.delete();
      bq.push_back(8'haa); bq.push_back(8'hbb); bq.push_back(8'hcc);
      bq.push_back(8'hdd); bq.push_back(8'h11); bq.push_back(8'h22);
      start_and_clear();
      send(1'b1, 1'b0);
      check_status("partial", 2, 1'b0, 1'b1);
      addr = 6'd0;
      #1;
      chk("partial_q0", q, 32'hddccbbaa);
      addr = 6'd1;
      #1;
      chk("partial_q1", q, 32'h00002211);

      // Randomized scenario table
      for (int v = 0; v < 8; v++) begin
         bq.delete();
         for (int i = 0; i < vecs[v].nbytes; i++) bq.push_back(8'($urandom));
         start_and_clear();
         send(vecs[v].last, vecs[v].bubbles);
         check_status($sformatf("vec%0d", v), vecs[v].exp_words, vecs[v].exp_done, vecs[v].exp_err);
         check_mem((vecs[v].nbytes > 256) ? 256 : vecs[v].nbytes);
      end

      // Asynchronous reset in the middle of a load
      bq.delete();
      for (int i = 0; i < 5; i++) bq.push_back(8'($urandom));
      start_and_clear();
      send(1'b0, 1'b0);
      chk("midload_words", 32'(words_loaded), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      addr = 6'd0;
      #1;
      chk("async_rst_q0", q, {bq[3], bq[2], bq[1], bq[0]});
      @(negedge clk);
      reset_n = 1'b1;
      bq.delete();
      for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
      start_and_clear();
      send(1'b1, 1'b1);
      check_status("reload", 2, 1'b1, 1'b0);
      check_mem(8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
